mips_multicycle_control: RTL and testbench

- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over shared ALU, memory and register file.
- Drives ALU select directly for address, PC and I-type ops. For R-type it forwards the 3-bit select produced by the function-code ALU decoder.
- Handles a ready handshake for variable-latency memory, with an optional timeout.

---
 rtl/mips_multicycle_control.sv | 230 +++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - Moore main control FSM for the multi-cycle MIPS datapath
//
// Sequences fetch, decode, execute, memory and writeback over a shared ALU,
// memory port and register file. Outputs are decoded from the registered
// state, plus alu_zero in BRANCH and mem_ready in the memory wait states.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode              IR[31:26], stable from DECODE until the next FETCH
//   funct_alu_sel       ALU select from the function-code decoder (R-type)
//   alu_zero            ALU zero flag (branch resolution)
//   mem_ready           memory access completes this cycle
//   pc_write..alu_sel   datapath control strobes and mux selects
//   state               current state code (debug)
//   illegal_op          sticky: unsupported opcode reached DECODE
//   mem_timeout         sticky: memory wait exceeded MEM_WAIT_MAX
module mips_multicycle_control #(
    parameter int unsigned MEM_WAIT_MAX = 0,
    parameter int unsigned WAIT_CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [2:0] funct_alu_sel,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_sel,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_HALT     = 4'd12,
        S_TIMEOUT  = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_WAIT_MAX);
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE   = WAIT_CNT_W'(1);
    localparam bit                    TIMEOUT_EN = (MEM_WAIT_MAX != 0);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    illegal_op_q, illegal_op_d;
    logic                    mem_timeout_q, mem_timeout_d;
    logic                    wait_expired;
    logic                    in_wait;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            wait_cnt_q    <= '0;
            illegal_op_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            illegal_op_q  <= illegal_op_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_sel       = 3'b000;
        state_d       = state_q;
        illegal_op_d  = illegal_op_q;
        mem_timeout_d = mem_timeout_q;
        wait_expired  = TIMEOUT_EN && (wait_cnt_q == WAIT_LIMIT);
        in_wait       = 1'b0;

        case (state_q)
            S_FETCH: begin
                in_wait   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_sel   = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_sel   = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:                        state_d = S_MEM_ADDR;
                    OP_R:                                state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE:                      state_d = S_BRANCH;
                    OP_J:                                state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_d = S_I_EXEC;
                    default: begin
                        state_d      = S_HALT;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                in_wait  = 1'b1;
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                in_wait   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_sel   = funct_alu_sel;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_sel   = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                state_d  = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI: alu_sel = ALU_AND;
                    OP_ORI:  alu_sel = ALU_OR;
                    OP_SLTI: alu_sel = ALU_SUB;
                    default: alu_sel = ALU_ADD;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:    state_d = S_HALT;
            S_TIMEOUT: state_d = S_TIMEOUT;
            default:   state_d = S_FETCH;
        endcase

        // A wait state that is not completing either times out or counts
        // one more wait cycle; ready on the limit cycle still completes.
        if (in_wait && !mem_ready && wait_expired) begin
            state_d       = S_TIMEOUT;
            mem_timeout_d = 1'b1;
        end

        // Every path other than "still waiting" leaves the counter at zero,
        // so each wait state is always entered with a cleared count.
        wait_cnt_d = (in_wait && !mem_ready && (state_d == state_q))
                   ? wait_cnt_q + WAIT_ONE : '0;
    end

    assign state       = state_q;
    assign illegal_op  = illegal_op_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - self-checking bench for mips_multicycle_control
module tb_mips_multicycle_control;

    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] ADDI = 6'h08, ANDI = 6'h0c, ORI = 6'h0d, SLTI = 6'h0a, J = 6'h02;
    localparam logic [5:0] BAD = 6'h3f;

    logic       clk = 1'b0;
    logic       reset, alu_zero, mem_ready;
    logic [5:0] opcode;
    logic [2:0] funct_alu_sel;
    logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_sel;
    logic [3:0] state;
    logic       illegal_op, mem_timeout;
    logic [17:0] dut_ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.MEM_WAIT_MAX(4), .WAIT_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct_alu_sel(funct_alu_sel),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_sel(alu_sel), .state(state),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    assign dut_ctl = {pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
                      reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_sel, illegal_op, mem_timeout};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [2:0]  fn;
        logic        az;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] ctl;
    } vec_t;

    vec_t tbl[$];
    vec_t rq[$];

    // Expected control word for one cycle of a given state, from the state table.
    function automatic logic [17:0] ctl(int s, logic [2:0] sel, logic pw);
        logic       pwr, irw, mrd, mwr, io, rw, rd, m2r, a, ill, to;
        logic [1:0] ps, b;
        logic [2:0] alu;
        {pwr, irw, mrd, mwr, io, rw, rd, m2r, a, ill, to} = '0;
        ps = 2'b00; b = 2'b00; alu = 3'b000;
        case (s)
            0:  begin mrd = 1; b = 2'b01; alu = 3'b010; pwr = pw; irw = pw; end
            1:  begin b = 2'b11; alu = 3'b010; end
            2:  begin a = 1; b = 2'b10; alu = 3'b010; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin a = 1; alu = sel; end
            7:  begin rw = 1; rd = 1; end
            8:  begin a = 1; alu = 3'b100; ps = 2'b01; pwr = pw; end
            9:  begin pwr = 1; ps = 2'b10; end
            10: begin a = 1; b = 2'b10; alu = sel; end
            11: begin rw = 1; end
            12: ill = 1;
            13: to = 1;
            default: ;
        endcase
        return {pwr, ps, irw, mrd, mwr, io, rw, rd, m2r, a, b, alu, ill, to};
    endfunction

    function automatic vec_t v(logic rst, logic [5:0] op, logic [2:0] fn, logic az, logic mr,
                               logic [3:0] st, logic [17:0] c);
        vec_t t;
        t.rst = rst; t.op = op; t.fn = fn; t.az = az; t.mr = mr; t.st = st; t.ctl = c;
        return t;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic apply(input vec_t t, input string tag, input int idx);
        reset = t.rst; opcode = t.op; funct_alu_sel = t.fn; alu_zero = t.az; mem_ready = t.mr;
        #2;
        if (!t.rst) begin
            checks++;
            if (state !== t.st || dut_ctl !== t.ctl) begin
                errors++;
                $display("FAIL %s row %0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                         tag, idx, state, dut_ctl, t.st, t.ctl);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic add(logic rst, logic [5:0] op, logic [2:0] fn, logic az, logic mr,
                       int st, logic [17:0] c);
        rq.push_back(v(rst, op, fn, az, mr, 4'(st), c));
    endtask

    // One memory access of the instruction-level model: w wait cycles, then
    // either completion or, past the limit of 4 counted waits, TIMEOUT + reset.
    task automatic mem_access(int st, int w, logic [5:0] op, logic [2:0] fn, logic az,
                              logic go_pw, output bit timed_out);
        for (int i = 0; i < w; i++) add(0, op, fn, az, 0, st, ctl(st, 0, 0));
        timed_out = (w >= 5);
        if (timed_out) begin
            add(0, op, fn, az, rbit(), 13, ctl(13, 0, 0));
            add(0, op, fn, az, rbit(), 13, ctl(13, 0, 0));
            add(1, op, fn, az, rbit(), 0, '0);
        end else begin
            add(0, op, fn, az, 1, st, ctl(st, 0, go_pw));
        end
    endtask

    logic [5:0] ops [10] = '{R, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, SLTI, J};

    initial begin
        // R-type after reset
        tbl.push_back(v(1, R, 3'b100, 0, 1, 0, '0));
        tbl.push_back(v(1, R, 3'b100, 0, 1, 0, '0));
        tbl.push_back(v(0, R, 3'b100, 0, 1, 0, ctl(0, 0, 1)));
        tbl.push_back(v(0, R, 3'b100, 0, 1, 1, ctl(1, 0, 0)));
        tbl.push_back(v(0, R, 3'b100, 0, 1, 6, ctl(6, 3'b100, 0)));
        tbl.push_back(v(0, R, 3'b100, 0, 1, 7, ctl(7, 0, 0)));
        // lw with three wait cycles in MEM_RD
        tbl.push_back(v(0, LW, 0, 0, 1, 0, ctl(0, 0, 1)));
        tbl.push_back(v(0, LW, 0, 0, 1, 1, ctl(1, 0, 0)));
        tbl.push_back(v(0, LW, 0, 0, 1, 2, ctl(2, 0, 0)));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, LW, 0, 0, 0, 3, ctl(3, 0, 0)));
        tbl.push_back(v(0, LW, 0, 0, 1, 3, ctl(3, 0, 0)));
        tbl.push_back(v(0, LW, 0, 0, 1, 4, ctl(4, 0, 0)));
        // beq taken, bne not taken, both with alu_zero=1
        tbl.push_back(v(0, BEQ, 0, 1, 1, 0, ctl(0, 0, 1)));
        tbl.push_back(v(0, BEQ, 0, 1, 1, 1, ctl(1, 0, 0)));
        tbl.push_back(v(0, BEQ, 0, 1, 1, 8, ctl(8, 0, 1)));
        tbl.push_back(v(0, BNE, 0, 1, 1, 0, ctl(0, 0, 1)));
        tbl.push_back(v(0, BNE, 0, 1, 1, 1, ctl(1, 0, 0)));
        tbl.push_back(v(0, BNE, 0, 1, 1, 8, ctl(8, 0, 0)));
        // illegal opcode halts until reset
        tbl.push_back(v(0, BAD, 0, 0, 1, 0, ctl(0, 0, 1)));
        tbl.push_back(v(0, BAD, 0, 0, 1, 1, ctl(1, 0, 0)));
        for (int i = 0; i < 10; i++) tbl.push_back(v(0, BAD, 0, 0, 1, 12, ctl(12, 0, 0)));
        tbl.push_back(v(1, BAD, 0, 0, 0, 0, '0));
        // fetch wait: five unready cycles then TIMEOUT, ready ignored there
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, R, 0, 0, 0, 0, ctl(0, 0, 0)));
        tbl.push_back(v(0, R, 0, 0, 1, 13, ctl(13, 0, 0)));
        tbl.push_back(v(0, R, 0, 0, 1, 13, ctl(13, 0, 0)));
        tbl.push_back(v(1, R, 0, 0, 0, 0, '0));
        // ready on the limit cycle wins over timeout
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, J, 0, 0, 0, 0, ctl(0, 0, 0)));
        tbl.push_back(v(0, J, 0, 0, 1, 0, ctl(0, 0, 1)));
        tbl.push_back(v(0, J, 0, 0, 1, 1, ctl(1, 0, 0)));
        tbl.push_back(v(0, J, 0, 0, 1, 9, ctl(9, 0, 0)));
        // reset in the middle of a store
        tbl.push_back(v(0, SW, 0, 0, 1, 0, ctl(0, 0, 1)));
        tbl.push_back(v(0, SW, 0, 0, 1, 1, ctl(1, 0, 0)));
        tbl.push_back(v(0, SW, 0, 0, 1, 2, ctl(2, 0, 0)));
        tbl.push_back(v(0, SW, 0, 0, 0, 5, ctl(5, 0, 0)));
        tbl.push_back(v(1, SW, 0, 0, 0, 5, '0));
        tbl.push_back(v(0, SW, 0, 0, 0, 0, ctl(0, 0, 0)));
        tbl.push_back(v(1, R, 0, 0, 0, 0, '0));

        reset = 1; opcode = R; funct_alu_sel = 0; alu_zero = 0; mem_ready = 0;
        @(posedge clk); #1;
        foreach (tbl[i]) apply(tbl[i], "directed", i);

        // Randomized instruction stream against the instruction-level model
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            logic [2:0] fn, isel;
            logic       az;
            int         r, w0, w1;
            bit         to;
            r  = $urandom_range(0, 15);
            op = (r == 10) ? BAD : ops[r % 10];
            fn = 3'($urandom_range(0, 7));
            az = rbit();
            w0 = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 4);
            w1 = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 4);
            case (op)
                ANDI:    isel = 3'b000;
                ORI:     isel = 3'b001;
                SLTI:    isel = 3'b100;
                default: isel = 3'b010;
            endcase
            rq.delete();
            mem_access(0, w0, op, fn, az, 1'b1, to);
            if (!to) begin
                add(0, op, fn, az, rbit(), 1, ctl(1, 0, 0));
                case (op)
                    R:    begin add(0, op, fn, az, rbit(), 6, ctl(6, fn, 0));
                                add(0, op, fn, az, rbit(), 7, ctl(7, 0, 0)); end
                    LW:   begin add(0, op, fn, az, rbit(), 2, ctl(2, 0, 0));
                                mem_access(3, w1, op, fn, az, 1'b0, to);
                                if (!to) add(0, op, fn, az, rbit(), 4, ctl(4, 0, 0)); end
                    SW:   begin add(0, op, fn, az, rbit(), 2, ctl(2, 0, 0));
                                mem_access(5, w1, op, fn, az, 1'b0, to); end
                    BEQ:  add(0, op, fn, az, rbit(), 8, ctl(8, 0, az));
                    BNE:  add(0, op, fn, az, rbit(), 8, ctl(8, 0, ~az));
                    J:    add(0, op, fn, az, rbit(), 9, ctl(9, 0, 0));
                    ADDI, ANDI, ORI, SLTI: begin
                          add(0, op, fn, az, rbit(), 10, ctl(10, isel, 0));
                          add(0, op, fn, az, rbit(), 11, ctl(11, 0, 0)); end
                    default: begin
                          for (int i = 0; i < 3; i++) add(0, op, fn, az, rbit(), 12, ctl(12, 0, 0));
                          add(1, op, fn, az, rbit(), 0, '0); end
                endcase
            end
            foreach (rq[i]) apply(rq[i], "random", n * 100 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
